simple_fsm: RTL and testbench
=============================

# simple_fsm

Loop-buffer controller between instruction fetch and decode. It detects a short backward conditional branch and captures one full iteration of the loop body. It then replays that body from an internal buffer while blocking fetch. A mispredict exits the loop: the controller pulses flush and redirects the PC to the fall-through address.

## Interface
- DEPTH, 8, maximum loop body length in instructions (branch included)
- XLEN, 32, instruction/PC width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- curr_PC  in  XLEN  PC of the instruction presented this cycle
- instruction  in  XLEN  fetched instruction
- immediate  in  XLEN  decoded branch offset, signed, in instruction words (byte offset = immediate*4)
- mispredict  in  1  branch-resolution mispredict of the loop branch
- block_signal  out  1  high while replaying; fetch must stall
- flush  out  1  one-cycle pulse on loop exit
- new_pc  out  XLEN  replay PC, or redirect PC on flush
- out_instruction  out  XLEN  instruction forwarded to decode

## Operation
- Loop branch: opcode instruction[6:0] == 7'b1100011, immediate[31]==1, and L = 1 - immediate with 2 ≤ L ≤ DEPTH.
- States: IDLE, CAPTURE, REPLAY.
- IDLE:
  - out_instruction <= instruction; new_pc <= curr_PC; block_signal=0.
  - On a loop branch, latch loop_pc=curr_PC, target=curr_PC+4*immediate, len=L, branch word; clear valid mask; go CAPTURE.
- CAPTURE: pass-through as in IDLE.
  - If target ≤ curr_PC ≤ loop_pc, write buf[(curr_PC-target)>>2] = instruction and set its valid bit.
  - If curr_PC == loop_pc, instruction equals the latched branch word, and all len entries are valid: go REPLAY with ptr=0.
  - If curr_PC == loop_pc but any entry is missing: stay in CAPTURE.
  - If curr_PC is outside [target, loop_pc], or mispredict=1: go IDLE, no flush.
- REPLAY:
  - block_signal=1; inputs curr_PC, instruction and immediate are ignored.
  - Each cycle: out_instruction <= buf[ptr]; new_pc <= target+4*ptr; ptr <= (ptr==len-1) ? 0 : ptr+1.
- Mispredict in REPLAY: flush=1 for one cycle; new_pc <= loop_pc+4; out_instruction <= 32'h00000013 (NOP); block_signal <= 0; go IDLE.
- Mispredict in IDLE is ignored.
- PC arithmetic is modulo 2^XLEN.

## Timing
- All outputs are registered; 1-cycle latency from the sampling edge.
- Reset values: block_signal=0, flush=0, new_pc=0, out_instruction=0, state=IDLE, ptr=0, valid mask cleared.
- Reset asserted mid-replay returns immediately to IDLE with the reset values above.
- Mispredict has priority over a same-cycle capture completion or replay advance.
- After flush, the next loop branch can be detected the cycle after returning to IDLE.
- A non-qualifying branch (forward, L > DEPTH, or L < 2) never leaves IDLE.

## Structure
- Shared package contents:
  - state enum {IDLE, CAPTURE, REPLAY}
  - BRANCH_OPCODE = 7'b1100011
  - NOP = 32'h00000013
  - default DEPTH
- Natural sub-module: loop_buffer, a DEPTH×XLEN register file with one write port, one read port and a valid mask.
- The FSM, pointer and PC arithmetic stay in the top module.

## Test plan
- Reset: hold reset=0 for 2 cycles -> all outputs 0; pass-through starts after release.
- Capture and replay:
  - Stimulus: loop 0x100:13, 0x104:14, 0x108:15, 0x10C:FC000AE3 with immediate=-3, run 3 iterations.
  - Detect at the first 0x10C; capture through the second 0x10C; then block_signal=1.
  - out_instruction cycles 13, 14, 15, FC000AE3 with new_pc 0x100, 0x104, 0x108, 0x10C, and continues while inputs are 0.
- Mispredict during replay -> one-cycle flush, new_pc=0x110, out_instruction=0x13, block_signal=0.
- Second loop 0x110–0x11C with immediate=-3 -> replays 16, 17, 18, FC000AE3; a later mispredict yields new_pc=0x120.
- immediate=-9 (L=10 > DEPTH) or a forward branch -> stays in IDLE, block_signal never set.
- Out-of-range PC (e.g. 0x200) during CAPTURE -> returns to IDLE, no flush, pass-through continues.

Source files
------------

// File: rtl/simple_fsm_pkg.sv
// Shared types and constants for the loop-buffer controller.
package simple_fsm_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        REPLAY  = 2'd2
    } state_t;

    localparam logic [6:0]  BRANCH_OPCODE = 7'b1100011;
    localparam logic [31:0] NOP           = 32'h00000013;
    localparam int          DEFAULT_DEPTH = 8;
endpackage

// File: rtl/simple_fsm_loop_buffer.sv
// Loop body storage: one write port, one combinational read port, per-entry valid mask.
module simple_fsm_loop_buffer #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [XLEN-1:0]  wr_data,
    input  logic [IW-1:0]    rd_idx,
    output logic [XLEN-1:0]  rd_data,
    output logic [DEPTH-1:0] valid
);
    logic [XLEN-1:0] mem [DEPTH];

    // Data is only read after every entry of the body is marked valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     valid <= '0;
        else if (clear) valid <= '0;
        else if (wr_en) valid[wr_idx] <= 1'b1;
    end

    assign rd_data = mem[rd_idx];
endmodule

// File: rtl/simple_fsm.sv
// Loop-buffer controller: detects a short backward branch, captures one iteration, replays it until mispredict.
module simple_fsm
    import simple_fsm_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] curr_PC,
    input  logic [XLEN-1:0] instruction,
    input  logic [XLEN-1:0] immediate,
    input  logic            mispredict,
    output logic            block_signal,
    output logic            flush,
    output logic [XLEN-1:0] new_pc,
    output logic [XLEN-1:0] out_instruction
);
    localparam int IW = $clog2(DEPTH);

    state_t          state;
    logic [XLEN-1:0] loop_pc, target, branch_word;
    logic [IW:0]     len;
    logic [IW-1:0]   ptr;

    logic [XLEN-1:0]  len_full, offset, rd_data, replay_pc;
    logic [DEPTH-1:0] valid, wr_onehot, len_mask, valid_next;
    logic [IW-1:0]    wr_idx;
    logic             is_loop_branch, in_range, wr_en, clear, capture_done, ptr_last;

    assign len_full       = XLEN'(1) - immediate;
    assign is_loop_branch = (instruction[6:0] == BRANCH_OPCODE) && immediate[XLEN-1]
                            && (len_full >= XLEN'(2)) && (len_full <= XLEN'(DEPTH));

    assign offset    = curr_PC - target;
    assign in_range  = (curr_PC >= target) && (curr_PC <= loop_pc);
    assign wr_idx    = IW'(offset >> 2);
    assign wr_en     = (state == CAPTURE) && in_range;
    assign clear     = (state == IDLE) && is_loop_branch;
    assign wr_onehot = wr_en ? (DEPTH'(1) << wr_idx) : '0;

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < DEPTH; i++) len_mask[i] = (i < int'(len));
    end

    // The branch itself is written on the completing cycle, so count this cycle's write as valid.
    assign valid_next   = valid | wr_onehot;
    assign capture_done = (curr_PC == loop_pc) && (instruction == branch_word)
                          && ((valid_next & len_mask) == len_mask);

    assign ptr_last  = ({1'b0, ptr} == (len - (IW+1)'(1)));
    assign replay_pc = target + XLEN'({ptr, 2'b00});

    simple_fsm_loop_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .IW(IW)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (instruction),
        .rd_idx  (ptr),
        .rd_data (rd_data),
        .valid   (valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            ptr             <= '0;
            len             <= '0;
            loop_pc         <= '0;
            target          <= '0;
            branch_word     <= '0;
            block_signal    <= 1'b0;
            flush           <= 1'b0;
            new_pc          <= '0;
            out_instruction <= '0;
        end else begin
            flush        <= 1'b0;
            block_signal <= 1'b0;
            case (state)
                IDLE: begin
                    out_instruction <= instruction;
                    new_pc          <= curr_PC;
                    if (is_loop_branch) begin
                        loop_pc     <= curr_PC;
                        target      <= curr_PC + (immediate << 2);
                        len         <= (IW+1)'(len_full);
                        branch_word <= instruction;
                        state       <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    out_instruction <= instruction;
                    new_pc          <= curr_PC;
                    if (mispredict || !in_range) begin
                        state <= IDLE;
                    end else if (capture_done) begin
                        state <= REPLAY;
                        ptr   <= '0;
                    end
                end
                REPLAY: begin
                    if (mispredict) begin
                        flush           <= 1'b1;
                        new_pc          <= loop_pc + XLEN'(4);
                        out_instruction <= NOP;
                        state           <= IDLE;
                    end else begin
                        block_signal    <= 1'b1;
                        out_instruction <= rd_data;
                        new_pc          <= replay_pc;
                        ptr             <= ptr_last ? '0 : ptr + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simple_fsm.sv
// Scenario bench for simple_fsm: expected outputs queued at drive time, compared after each test.
module tb_simple_fsm;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] curr_PC = '0, instruction = '0, immediate = '0;
    logic        mispredict = 1'b0;
    logic        block_signal, flush;
    logic [31:0] new_pc, out_instruction;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        blk;
        logic        fl;
    } obs_t;

    obs_t exp_q[$], obs_q[$];
    int vectors = 0, miscompares = 0;

    localparam logic [31:0] M3 = 32'hFFFF_FFFD;
    localparam logic [31:0] BR = 32'hFC00_0AE3;

    simple_fsm #(.DEPTH(8), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .curr_PC(curr_PC), .instruction(instruction),
        .immediate(immediate), .mispredict(mispredict), .block_signal(block_signal),
        .flush(flush), .new_pc(new_pc), .out_instruction(out_instruction)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic [31:0] pc, ins, imm, input logic mp,
                         input logic [31:0] e_pc, e_ins, input logic e_blk, e_fl);
        obs_t o;
        curr_PC = pc; instruction = ins; immediate = imm; mispredict = mp;
        exp_q.push_back({e_pc, e_ins, e_blk, e_fl});
        @(posedge clk); #1;
        o = {new_pc, out_instruction, block_signal, flush};
        obs_q.push_back(o);
    endtask

    task automatic pass(input logic [31:0] pc, ins, imm);
        apply(pc, ins, imm, 1'b0, pc, ins, 1'b0, 1'b0);
    endtask

    task automatic rep(input logic [31:0] e_pc, e_ins);
        apply('0, '0, '0, 1'b0, e_pc, e_ins, 1'b1, 1'b0);
    endtask

    task automatic test_reset;
        obs_t o, e;
        reset = 1'b0; curr_PC = 32'h40; instruction = 32'h13; immediate = M3;
        repeat (2) @(posedge clk);
        #1;
        o = {new_pc, out_instruction, block_signal, flush};
        e = '0;
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL reset_values: got %h want %h", o, e);
        end
        @(negedge clk); reset = 1'b1;
        pass(32'h40, 32'h13, '0);
        pass(32'h44, 32'h93, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset_release: got pc=%h ins=%h blk=%b fl=%b want pc=%h ins=%h blk=%b fl=%b",
                         o.pc, o.ins, o.blk, o.fl, e.pc, e.ins, e.blk, e.fl);
            end
        end
    endtask

    task automatic test_capture_replay;
        obs_t o, e;
        repeat (2) begin
            pass(32'h100, 32'h13, '0);
            pass(32'h104, 32'h14, '0);
            pass(32'h108, 32'h15, '0);
            pass(32'h10C, BR, M3);
        end
        for (int i = 0; i < 9; i++) begin
            case (i % 4)
                0: rep(32'h100, 32'h13);
                1: rep(32'h104, 32'h14);
                2: rep(32'h108, 32'h15);
                default: rep(32'h10C, BR);
            endcase
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL capture_replay: got pc=%h ins=%h blk=%b fl=%b want pc=%h ins=%h blk=%b fl=%b",
                         o.pc, o.ins, o.blk, o.fl, e.pc, e.ins, e.blk, e.fl);
            end
        end
    endtask

    task automatic test_mispredict;
        obs_t o, e;
        apply('0, '0, '0, 1'b1, 32'h110, 32'h13, 1'b0, 1'b1);
        pass(32'h0, 32'h0, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mispredict_flush: got pc=%h ins=%h blk=%b fl=%b want pc=%h ins=%h blk=%b fl=%b",
                         o.pc, o.ins, o.blk, o.fl, e.pc, e.ins, e.blk, e.fl);
            end
        end
    endtask

    task automatic test_second_loop;
        obs_t o, e;
        repeat (2) begin
            pass(32'h110, 32'h16, '0);
            pass(32'h114, 32'h17, '0);
            pass(32'h118, 32'h18, '0);
            pass(32'h11C, BR, M3);
        end
        rep(32'h110, 32'h16);
        rep(32'h114, 32'h17);
        rep(32'h118, 32'h18);
        rep(32'h11C, BR);
        rep(32'h110, 32'h16);
        apply(32'h114, 32'h17, '0, 1'b1, 32'h120, 32'h13, 1'b0, 1'b1);
        pass(32'h120, 32'h93, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL second_loop: got pc=%h ins=%h blk=%b fl=%b want pc=%h ins=%h blk=%b fl=%b",
                         o.pc, o.ins, o.blk, o.fl, e.pc, e.ins, e.blk, e.fl);
            end
        end
    endtask

    task automatic test_non_qualifying;
        obs_t o, e;
        // Nine-instruction body (L=9 > DEPTH) run twice, then a forward branch: never replays.
        repeat (2) begin
            for (int i = 0; i < 8; i++) pass(32'h500 + 32'(4 * i), 32'h13 | 32'(i << 7), '0);
            pass(32'h520, BR, 32'hFFFF_FFF8);
        end
        pass(32'h0, 32'h0, '0);
        pass(32'h600, 32'h0000_0263, 32'h2);
        pass(32'h604, 32'h13, '0);
        pass(32'h600, 32'h0000_0263, 32'h2);
        pass(32'h604, 32'h13, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL non_qualifying: got pc=%h ins=%h blk=%b fl=%b want pc=%h ins=%h blk=%b fl=%b",
                         o.pc, o.ins, o.blk, o.fl, e.pc, e.ins, e.blk, e.fl);
            end
        end
    endtask

    task automatic test_out_of_range;
        obs_t o, e;
        pass(32'h10C, BR, M3);
        pass(32'h100, 32'h13, '0);
        pass(32'h200, 32'h93, '0);
        pass(32'h104, 32'h14, '0);
        pass(32'h108, 32'h15, '0);
        pass(32'h10C, BR, '0);
        repeat (3) pass(32'h0, 32'h0, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL out_of_range: got pc=%h ins=%h blk=%b fl=%b want pc=%h ins=%h blk=%b fl=%b",
                         o.pc, o.ins, o.blk, o.fl, e.pc, e.ins, e.blk, e.fl);
            end
        end
    endtask

    task automatic test_max_len;
        obs_t o, e;
        repeat (2) begin
            for (int i = 0; i < 7; i++) pass(32'h700 + 32'(4 * i), 32'h13 | 32'(i << 7), '0);
            pass(32'h71C, 32'hFE00_0EE3, 32'hFFFF_FFF9);
        end
        for (int i = 0; i < 7; i++) rep(32'h700 + 32'(4 * i), 32'h13 | 32'(i << 7));
        rep(32'h71C, 32'hFE00_0EE3);
        rep(32'h700, 32'h13);
        apply('0, '0, '0, 1'b1, 32'h720, 32'h13, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL max_len: got pc=%h ins=%h blk=%b fl=%b want pc=%h ins=%h blk=%b fl=%b",
                         o.pc, o.ins, o.blk, o.fl, e.pc, e.ins, e.blk, e.fl);
            end
        end
    endtask

    task automatic test_reset_mid_replay;
        obs_t o, e;
        repeat (2) begin
            pass(32'h100, 32'h13, '0);
            pass(32'h104, 32'h14, '0);
            pass(32'h108, 32'h15, '0);
            pass(32'h10C, BR, M3);
        end
        rep(32'h100, 32'h13);
        rep(32'h104, 32'h14);
        #2 reset = 1'b0;
        #1;
        o = {new_pc, out_instruction, block_signal, flush};
        vectors++;
        if (o !== obs_t'(0)) begin
            miscompares++;
            $display("FAIL reset_mid_replay: got %h want %h", o, obs_t'(0));
        end
        @(negedge clk); reset = 1'b1;
        pass(32'h108, 32'h15, '0);
        pass(32'h0, 32'h0, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset_mid_replay_seq: got pc=%h ins=%h blk=%b fl=%b want pc=%h ins=%h blk=%b fl=%b",
                         o.pc, o.ins, o.blk, o.fl, e.pc, e.ins, e.blk, e.fl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture_replay();
        test_mispredict();
        test_second_loop();
        test_non_qualifying();
        test_out_of_range();
        test_max_len();
        test_reset_mid_replay();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
